// File: rtl/register_file.sv
// RV32I integer register file: x0 reads as zero, two combinational read ports, one clocked write port.
// Registers 1..NUM_REGS-1 are flops. x0 has no storage behind it.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  Clk_Core,
  input  logic                  Rst_Core,
  input  logic [ADDR_WIDTH-1:0] Read_Addr_Port_1,
  output logic [DATA_WIDTH-1:0] Read_Data_Port_1,
  input  logic [ADDR_WIDTH-1:0] Read_Addr_Port_2,
  output logic [DATA_WIDTH-1:0] Read_Data_Port_2,
  input  logic [ADDR_WIDTH-1:0] Write_Addr_Port_1,
  input  logic [DATA_WIDTH-1:0] Write_Data_Port_1,
  input  logic                  Wr_En
);

  logic [DATA_WIDTH-1:0] regs_reg [1:NUM_REGS-1];

  // One flop group per architectural register. An address of 0 or >= NUM_REGS never matches any group.
  // Reset is checked before the write, so a write in a reset cycle is dropped.
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic wr_hit;
      assign wr_hit = Wr_En && (Write_Addr_Port_1 == ADDR_WIDTH'(gi));

      always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
          regs_reg[gi] <= '0;
        end else if (wr_hit) begin
          regs_reg[gi] <= Write_Data_Port_1;
        end
      end
    end
  endgenerate

  // Reads return the value currently stored, with no write-to-read bypass.
  // Any address that does not match a stored register reads as zero.
  always_comb begin
    Read_Data_Port_1 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (Read_Addr_Port_1 == ADDR_WIDTH'(i)) begin
        Read_Data_Port_1 = regs_reg[i];
      end
    end
  end

  always_comb begin
    Read_Data_Port_2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (Read_Addr_Port_2 == ADDR_WIDTH'(i)) begin
        Read_Data_Port_2 = regs_reg[i];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, x0 protection, fill/readback, write gating,
// same-cycle read/write, dual-port reads, and reset priority over a write.
module tb_register_file;

  logic        Clk_Core;
  logic        Rst_Core;
  logic [4:0]  Read_Addr_Port_1;
  logic [31:0] Read_Data_Port_1;
  logic [4:0]  Read_Addr_Port_2;
  logic [31:0] Read_Data_Port_2;
  logic [4:0]  Write_Addr_Port_1;
  logic [31:0] Write_Data_Port_1;
  logic        Wr_En;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_mem [0:31];

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS(32)
  ) dut (
    .Clk_Core(Clk_Core),
    .Rst_Core(Rst_Core),
    .Read_Addr_Port_1(Read_Addr_Port_1),
    .Read_Data_Port_1(Read_Data_Port_1),
    .Read_Addr_Port_2(Read_Addr_Port_2),
    .Read_Data_Port_2(Read_Data_Port_2),
    .Write_Addr_Port_1(Write_Addr_Port_1),
    .Write_Data_Port_1(Write_Data_Port_1),
    .Wr_En(Wr_En)
  );

  initial Clk_Core = 1'b0;
  always #5 Clk_Core = ~Clk_Core;

  task automatic tick();
    @(posedge Clk_Core);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic read_both(input string tag, input logic [4:0] addr, input logic [31:0] expected);
    Read_Addr_Port_1 = addr;
    Read_Addr_Port_2 = addr;
    #1;
    check($sformatf("%s p1 a%0d", tag, addr), Read_Data_Port_1, expected);
    check($sformatf("%s p2 a%0d", tag, addr), Read_Data_Port_2, expected);
    $display("[TB] %s read addr %0d -> p1=%08h p2=%08h", tag, addr, Read_Data_Port_1, Read_Data_Port_2);
  endtask

  initial begin
    Rst_Core = 1'b1;
    Wr_En = 1'b0;
    Read_Addr_Port_1 = '0;
    Read_Addr_Port_2 = '0;
    Write_Addr_Port_1 = '0;
    Write_Data_Port_1 = '0;

    // Reset for two edges, then sweep every address on both ports.
    tick();
    tick();
    Rst_Core = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_both("reset", 5'(i), 32'h0);
    end

    // Write to x0 must be discarded.
    Wr_En = 1'b1;
    Write_Addr_Port_1 = 5'd0;
    Write_Data_Port_1 = 32'hDEADBEEF;
    tick();
    Wr_En = 1'b0;
    $display("[TB] x0 write DEADBEEF");
    read_both("x0", 5'd0, 32'h0);

    // Fill registers 1..31 with distinct data, one write per cycle.
    exp_mem[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      exp_mem[i] = (32'h9E3779B9 * i) ^ {i[7:0], 24'h5A3C00} ^ 32'(i);
      Wr_En = 1'b1;
      Write_Addr_Port_1 = 5'(i);
      Write_Data_Port_1 = exp_mem[i];
      tick();
      $display("[TB] fill write addr %0d data %08h", i, exp_mem[i]);
    end
    Wr_En = 1'b0;
    for (int i = 1; i < 32; i++) begin
      read_both("fill", 5'(i), exp_mem[i]);
    end

    // Wr_En low: address and data presented, nothing changes.
    Wr_En = 1'b0;
    Write_Addr_Port_1 = 5'd5;
    Write_Data_Port_1 = 32'h12345678;
    tick();
    read_both("gate", 5'd5, exp_mem[5]);

    // Same-cycle read/write of addr 7: old value before the edge, new value after.
    Read_Addr_Port_1 = 5'd7;
    Read_Addr_Port_2 = 5'd7;
    Wr_En = 1'b1;
    Write_Addr_Port_1 = 5'd7;
    Write_Data_Port_1 = 32'hCAFEF00D;
    #1;
    check("rw before edge", Read_Data_Port_1, exp_mem[7]);
    $display("[TB] rw addr 7 before edge p1=%08h", Read_Data_Port_1);
    tick();
    Wr_En = 1'b0;
    exp_mem[7] = 32'hCAFEF00D;
    check("rw after edge", Read_Data_Port_1, 32'hCAFEF00D);
    $display("[TB] rw addr 7 after edge p1=%08h", Read_Data_Port_1);

    // Independent addresses on the two ports.
    Read_Addr_Port_1 = 5'd3;
    Read_Addr_Port_2 = 5'd9;
    #1;
    check("dual p1 a3", Read_Data_Port_1, exp_mem[3]);
    check("dual p2 a9", Read_Data_Port_2, exp_mem[9]);
    $display("[TB] dual p1 a3=%08h p2 a9=%08h", Read_Data_Port_1, Read_Data_Port_2);

    // Reset has priority over a simultaneous write and clears everything.
    Rst_Core = 1'b1;
    Wr_En = 1'b1;
    Write_Addr_Port_1 = 5'd10;
    Write_Data_Port_1 = 32'hA5A5A5A5;
    tick();
    Rst_Core = 1'b0;
    Wr_En = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_both("rstprio", 5'(i), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
